// File: rtl/thr_cmp_sequencer.sv
// Sequencer for the STFT threshold-comparison stage: walks the spectrogram address space,
// enables the comparator per accepted sample and reports the registered decisions with position.
module thr_cmp_sequencer #(
  parameter int N_BIN = 128,
  parameter int N_FRM = 1024,
  parameter int AW    = 17,
  parameter int CW    = 18,
  localparam int BW   = (N_BIN > 1) ? $clog2(N_BIN) : 1,
  localparam int FW   = (N_FRM > 1) ? $clog2(N_FRM) : 1
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iSTART,
  input  logic          iABORT,
  input  logic          iVALID,
  output logic          oREADY,
  output logic [AW-1:0] oTH_ADDR,
  output logic          oCMP_EN,
  input  logic          iCMP,
  output logic          oVALID,
  output logic          oRESULT,
  output logic [BW-1:0] oBIN_IDX,
  output logic [FW-1:0] oFRM_IDX,
  output logic          oSOF,
  output logic [CW-1:0] oHIT_CNT,
  output logic          oBUSY,
  output logic          oDONE
);

  localparam int LAST = N_BIN * N_FRM - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [FW-1:0]   frm_q, frm_d;
  logic            pend_q, pend_d;
  logic [BW-1:0]   pbin_q, pbin_d;
  logic [FW-1:0]   pfrm_q, pfrm_d;
  logic [CW-1:0]   hit_q, hit_d;
  logic            accept;

  assign accept = iVALID && (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bin_d   = bin_q;
    frm_d   = frm_q;
    // The pending slot mirrors the comparator pipeline, so it captures even on an aborting accept.
    pend_d  = accept;
    pbin_d  = bin_q;
    pfrm_d  = frm_q;
    hit_d   = hit_q + CW'(pend_q & iCMP);

    case (state_q)
      S_IDLE: begin
        if (!iABORT && iSTART) begin
          state_d = S_RUN;
          addr_d  = '0;
          bin_d   = '0;
          frm_d   = '0;
          hit_d   = '0;
        end
      end
      S_RUN: begin
        if (iABORT) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if (addr_q == AW'(LAST)) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
            if (bin_q == BW'(N_BIN - 1)) begin
              bin_d = '0;
              frm_d = frm_q + FW'(1);
            end else begin
              bin_d = bin_q + BW'(1);
            end
          end
        end
      end
      S_DRAIN: state_d = iABORT ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      bin_q   <= '0;
      frm_q   <= '0;
      pend_q  <= 1'b0;
      pbin_q  <= '0;
      pfrm_q  <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bin_q   <= bin_d;
      frm_q   <= frm_d;
      pend_q  <= pend_d;
      pbin_q  <= pbin_d;
      pfrm_q  <= pfrm_d;
      hit_q   <= hit_d;
    end
  end

  assign oREADY   = (state_q == S_RUN);
  assign oCMP_EN  = accept;
  assign oTH_ADDR = addr_q;
  assign oVALID   = pend_q;
  assign oRESULT  = iCMP & pend_q;
  assign oBIN_IDX = pbin_q;
  assign oFRM_IDX = pfrm_q;
  assign oSOF     = pend_q && (pbin_q == '0);
  assign oHIT_CNT = hit_q;
  assign oBUSY    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign oDONE    = (state_q == S_DONE);

endmodule

// File: tb/tb_thr_cmp_sequencer.sv
// Scoreboard bench for thr_cmp_sequencer on a 4x2 spectrogram: the driver queues expected
// results per accept, an independent monitor checks every oVALID against the queue.
module tb_thr_cmp_sequencer;

  localparam int N_BIN = 4;
  localparam int N_FRM = 2;
  localparam int AW    = 3;
  localparam int CW    = 8;

  logic          iCLK = 1'b0;
  logic          iRSTn = 1'b0;
  logic          iSTART = 1'b0;
  logic          iABORT = 1'b0;
  logic          iVALID = 1'b0;
  logic          iCMP = 1'b0;
  logic          oREADY, oCMP_EN, oVALID, oRESULT, oSOF, oBUSY, oDONE;
  logic [AW-1:0] oTH_ADDR;
  logic [1:0]    oBIN_IDX;
  logic [0:0]    oFRM_IDX;
  logic [CW-1:0] oHIT_CNT;

  thr_cmp_sequencer #(.N_BIN(N_BIN), .N_FRM(N_FRM), .AW(AW), .CW(CW)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iSTART(iSTART), .iABORT(iABORT), .iVALID(iVALID),
    .oREADY(oREADY), .oTH_ADDR(oTH_ADDR), .oCMP_EN(oCMP_EN), .iCMP(iCMP),
    .oVALID(oVALID), .oRESULT(oRESULT), .oBIN_IDX(oBIN_IDX), .oFRM_IDX(oFRM_IDX),
    .oSOF(oSOF), .oHIT_CNT(oHIT_CNT), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int res;
    int bin;
    int frm;
    int sof;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] cmp_pat = 8'h00;

  // Threshold ROM plus registered comparator: decision for the enabled address appears next cycle.
  always @(posedge iCLK) iCMP <= oCMP_EN & cmp_pat[oTH_ADDR];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge iCLK) begin
    if (iRSTn && oVALID) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got oVALID=1, expected no pending result (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        $display("result frm=%0d bin=%0d sof=%0d res=%0d", oFRM_IDX, oBIN_IDX, oSOF, oRESULT);
        chk("result", int'(oRESULT), mon_e.res);
        chk("bin_idx", int'(oBIN_IDX), mon_e.bin);
        chk("frm_idx", int'(oFRM_IDX), mon_e.frm);
        chk("sof", int'(oSOF), mon_e.sof);
      end
    end
  end

  // mode 0: full pass, 1: abort after 5 accepts, 2: async reset at address 3
  task automatic run_pass(input logic [7:0] pat, input bit toggle, input int mode);
    int   k;
    int   cyc;
    int   last_acc;
    exp_t e;
    cmp_pat = pat;
    @(posedge iCLK); #1;
    iSTART = 1'b1;
    iVALID = 1'b1;
    @(negedge iCLK);
    chk("idle_ready", int'(oREADY), 0);
    chk("idle_cmp_en", int'(oCMP_EN), 0);
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    k = 0;
    cyc = 0;
    last_acc = 0;
    while (k < N_BIN * N_FRM && cyc < 100) begin
      if (mode == 1 && k == 5) begin
        iVALID = 1'b0;
        iABORT = 1'b1;
        @(negedge iCLK);
        chk("abort_valid", int'(oVALID), 1);
        chk("abort_cmp_en", int'(oCMP_EN), 0);
        @(posedge iCLK); #1;
        iABORT = 1'b0;
        @(negedge iCLK);
        chk("abort_busy", int'(oBUSY), 0);
        chk("abort_ready", int'(oREADY), 0);
        chk("abort_valid_gone", int'(oVALID), 0);
        chk("abort_hit", int'(oHIT_CNT), $countones(pat & 8'h1F));
        chk("abort_no_done", int'(oDONE), 0);
        @(posedge iCLK); #1;
        @(negedge iCLK);
        chk("abort_no_done2", int'(oDONE), 0);
        chk("abort_hit_hold", int'(oHIT_CNT), $countones(pat & 8'h1F));
        $display("pass aborted after %0d accepts", k);
        return;
      end
      if (mode == 2 && k == 3) begin
        iSTART = 1'b0;
        iVALID = 1'b1;
        iRSTn  = 1'b0;
        #1;
        chk("rst_addr", int'(oTH_ADDR), 0);
        chk("rst_hit", int'(oHIT_CNT), 0);
        chk("rst_valid", int'(oVALID), 0);
        chk("rst_busy", int'(oBUSY), 0);
        chk("rst_done", int'(oDONE), 0);
        chk("rst_sof", int'(oSOF), 0);
        chk("rst_bin", int'(oBIN_IDX), 0);
        chk("rst_frm", int'(oFRM_IDX), 0);
        chk("rst_cmp_en", int'(oCMP_EN), 0);
        exp_q.delete();
        @(posedge iCLK); #1;
        iRSTn = 1'b1;
        for (int i = 0; i < 2; i++) begin
          @(negedge iCLK);
          chk("post_rst_busy", int'(oBUSY), 0);
          chk("post_rst_cmp_en", int'(oCMP_EN), 0);
          chk("post_rst_addr", int'(oTH_ADDR), 0);
          @(posedge iCLK); #1;
        end
        iVALID = 1'b0;
        $display("pass reset at address %0d", k);
        return;
      end
      iVALID = toggle ? (cyc % 2 == 0) : 1'b1;
      iSTART = (cyc == 2);
      @(negedge iCLK);
      if (cyc == 0) chk("hit_clear", int'(oHIT_CNT), 0);
      chk("run_ready", int'(oREADY), 1);
      chk("cmp_en", int'(oCMP_EN), int'(iVALID));
      chk("th_addr", int'(oTH_ADDR), k);
      chk("valid_delay", int'(oVALID), last_acc);
      last_acc = int'(iVALID);
      if (iVALID) begin
        e.res = int'(pat[k]);
        e.bin = k % N_BIN;
        e.frm = k / N_BIN;
        e.sof = int'(k % N_BIN == 0);
        exp_q.push_back(e);
        $display("accept addr=%0d", k);
        k++;
      end
      cyc++;
      @(posedge iCLK); #1;
    end
    iVALID = 1'b0;
    iSTART = 1'b0;
    if (cyc >= 100) chk("accept_timeout", k, N_BIN * N_FRM);
    @(negedge iCLK);
    chk("drain_busy", int'(oBUSY), 1);
    chk("drain_done", int'(oDONE), 0);
    chk("drain_valid", int'(oVALID), 1);
    @(posedge iCLK); #1;
    @(negedge iCLK);
    chk("done_pulse", int'(oDONE), 1);
    chk("done_busy", int'(oBUSY), 0);
    chk("done_hit", int'(oHIT_CNT), $countones(pat));
    @(posedge iCLK); #1;
    @(negedge iCLK);
    chk("done_end", int'(oDONE), 0);
    chk("idle_busy", int'(oBUSY), 0);
    $display("pass done hits=%0d", oHIT_CNT);
  endtask

  initial begin
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    chk("reset_addr", int'(oTH_ADDR), 0);
    chk("reset_hit", int'(oHIT_CNT), 0);
    chk("reset_busy", int'(oBUSY), 0);
    chk("reset_valid", int'(oVALID), 0);
    chk("reset_done", int'(oDONE), 0);
    @(posedge iCLK); #1;
    iRSTn = 1'b1;

    run_pass(8'hFF, 1'b0, 0);
    run_pass(8'hFF, 1'b1, 0);
    run_pass(8'b0001_1001, 1'b0, 0);
    run_pass(8'hFF, 1'b0, 1);
    run_pass(8'b0001_1001, 1'b0, 0);
    run_pass(8'hFF, 1'b0, 2);
    run_pass(8'hA5, 1'b1, 0);

    repeat (2) @(negedge iCLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/thr_cmp_sequencer.md
# thr_cmp_sequencer

Sequencer for the threshold-comparison stage of the radar STFT detection path. It accepts a stream of STFT magnitude samples covering one full spectrogram (N_BIN bins × N_FRM frames). For each sample it drives the threshold-ROM address and the comparator enable, then collects the comparator's registered decision bit. It returns detection results with frame/bin position, a per-spectrogram hit count, and a start/busy/done handshake to the upstream control.

## Interface
- N_BIN, 128: STFT bins per frame; ≥2.
- N_FRM, 1024: frames per spectrogram; ≥1; N_BIN×N_FRM ≤ 2^AW.
- AW, 17: threshold-ROM address width.
- CW, 18: hit-counter width; must hold N_BIN×N_FRM.

Ports:
- iCLK  in  1  system clock; all state changes on the rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iSTART  in  1  start one spectrogram pass; sampled only in IDLE.
- iABORT  in  1  synchronous abort; returns to IDLE with no oDONE.
- iVALID  in  1  upstream magnitude sample valid this cycle.
- oREADY  out  1  high in RUN; a sample transfers when iVALID&oREADY.
- oTH_ADDR  out  AW  threshold-ROM address (frame×N_BIN+bin) for the current sample.
- oCMP_EN  out  1  comparator enable = iVALID&oREADY (combinational).
- iCMP  in  1  comparator registered decision; valid the cycle after oCMP_EN.
- oVALID  out  1  result valid; oRESULT/oBIN_IDX/oFRM_IDX/oSOF qualify on it.
- oRESULT  out  1  detection bit (iCMP passed through when oVALID).
- oBIN_IDX  out  log2(N_BIN)  bin index of the result.
- oFRM_IDX  out  log2(N_FRM) (min 1)  frame index of the result.
- oSOF  out  1  result is bin 0 of a frame.
- oHIT_CNT  out  CW  number of 1-results in the current/last pass.
- oBUSY  out  1  high in RUN and DRAIN.
- oDONE  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: when iSTART=1, clear the address, bin and frame counters and oHIT_CNT, then go to RUN. oHIT_CNT holds its last value until that clear.
- RUN: each accepted sample asserts oCMP_EN with oTH_ADDR = current address.
  - On each accept: address +1, bin +1.
  - When bin = N_BIN−1, bin wraps to 0 and frame +1.
  - An accept at address N_BIN×N_FRM−1 moves to DRAIN; counters then hold.
- Cycles with iVALID=0 in RUN are stalls: nothing changes and oCMP_EN=0.
- DRAIN: one cycle that collects the final comparator result, then DONE.
- DONE: oDONE=1 for one cycle, then IDLE.
- Result tracking:
  - A pending register (pend, bin_d, frm_d) captures oCMP_EN and the accepted sample's bin/frame on every edge.
  - oVALID = pend, oRESULT = iCMP & pend, oSOF = pend & (bin_d==0).
  - oHIT_CNT increments at the end of any cycle with pend&iCMP.
- iSTART outside IDLE is ignored. iVALID outside RUN is ignored; oCMP_EN stays 0.
- iABORT in RUN, DRAIN or DONE forces IDLE on the next edge.
  - A pending result still appears for one cycle after the abort.
  - oHIT_CNT holds its value; oDONE is not pulsed.
  - iABORT in IDLE has priority over iSTART.
- Reset: all state goes to IDLE. Every output and counter is 0: oTH_ADDR, oHIT_CNT, oVALID, oBUSY, oDONE, oSOF, oBIN_IDX, oFRM_IDX. This holds mid-pass as well.

## Timing
- oTH_ADDR, oBUSY, oREADY, oDONE, oBIN_IDX, oFRM_IDX, oSOF and oVALID are decoded from registers. oCMP_EN is combinational from iVALID.
- The threshold ROM is combinational; the comparator registers its decision on the edge that ends the oCMP_EN cycle.
- Accept at cycle t gives oVALID/oRESULT at t+1. The oHIT_CNT update is visible at t+2.
- For the last accept at t: DRAIN at t+1 (final oVALID), DONE/oDONE at t+2 with the final oHIT_CNT, IDLE at t+3.
- Minimum pass length is N_BIN×N_FRM+3 cycles from the cycle after iSTART.
- Back-to-back pass: iSTART may be asserted in the cycle the block returns to IDLE (t+3).

## Test plan
- Reset, then N_BIN=4, N_FRM=2, iVALID held high, iCMP=1 on every pend cycle:
  - oTH_ADDR steps 0..7 on consecutive cycles.
  - oSOF on results 0 and 4.
  - oDONE 2 cycles after the last accept; oHIT_CNT=8.
- Same pass with iVALID toggling 1,0,1,0:
  - Address advances only on accepts; oCMP_EN=0 on stall cycles.
  - oVALID pattern is delayed by exactly 1 cycle.
- iCMP pattern 1,0,0,1,1,0,0,0 → oHIT_CNT=3 at oDONE. oFRM_IDX=1 for results 4..7.
- iABORT after 5 accepts:
  - One more oVALID, then IDLE; no oDONE; oHIT_CNT retained.
  - A new iSTART clears oHIT_CNT to 0 and oTH_ADDR to 0.
- iRSTn low mid-RUN at address 3 → all outputs 0 immediately (asynchronous). Idle until iSTART.
- iSTART asserted during RUN is ignored. iVALID in IDLE produces no oCMP_EN.
